move_controller: RTL and testbench

- Player-input front end for the Connect Four board; sits directly upstream of the per-column token counters.
- Converts left/right/drop button levels into a cursor position and a one-cycle column-select code on drop_column.
- Every column counter compares drop_column against its own column number and increments on a match.
- Rejects drops into full columns, alternates players, and freezes on win or draw.

---
 rtl/move_if.sv | 29 ++
 rtl/move_controller.sv | 175 +++++++++++++++++
 tb/tb_move_controller.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/move_if.sv
// Player-input bus between the button/board side and the move controller.
// The board side drives buttons, column counts and the win flag; the
// controller drives cursor, column-select code and game status.
interface move_if #(
  parameter int NUM_COLS = 7
);
  logic                  btn_left;
  logic                  btn_right;
  logic                  btn_drop;
  logic [3*NUM_COLS-1:0] counts;
  logic                  game_won;
  logic [3:0]            cursor;
  logic [3:0]            drop_column;
  logic [2:0]            drop_row;
  logic                  player;
  logic                  reject;
  logic                  draw;
  logic                  game_over;

  modport master (
    output btn_left, btn_right, btn_drop, counts, game_won,
    input  cursor, drop_column, drop_row, player, reject, draw, game_over
  );

  modport slave (
    input  btn_left, btn_right, btn_drop, counts, game_won,
    output cursor, drop_column, drop_row, player, reject, draw, game_over
  );
endinterface

// File: rtl/move_controller.sv
// Connect Four player-input front end. Turns button levels into cursor moves
// and a one-cycle column-select code for the per-column token counters,
// rejects drops into full columns, alternates players and freezes at the end
// of the game.
module move_controller #(
  parameter int NUM_COLS  = 7,
  parameter int NUM_ROWS  = 6,
  parameter int START_COL = 4
) (
  input  logic   clk,
  input  logic   reset,
  move_if.slave  bus
);

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    DROP   = 2'd1,
    WAIT   = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam logic [3:0] LP_LAST  = 4'(NUM_COLS);
  localparam logic [3:0] LP_START = 4'(START_COL);
  localparam logic [2:0] LP_FULL  = 3'(NUM_ROWS);

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_hist_l;
  logic       r_hist_r;
  logic       r_hist_d;
  logic       w_ev_l;
  logic       w_ev_r;
  logic       w_ev_d;

  logic [3:0] r_cursor;
  logic [3:0] r_drop_col;
  logic [2:0] r_drop_row;
  logic       r_player;
  logic       r_reject;
  logic       r_draw;
  logic       r_over;

  logic [3:0] w_cursor_nxt;
  logic [3:0] w_drop_col_nxt;
  logic [2:0] w_drop_row_nxt;
  logic       w_player_nxt;
  logic       w_reject_nxt;
  logic       w_draw_nxt;
  logic       w_over_nxt;

  logic [2:0] w_cur_count;
  logic       w_col_full;
  logic       w_all_full;

  // Rising-edge events: button high now, low on the previous edge.
  assign w_ev_l = bus.btn_left  & ~r_hist_l;
  assign w_ev_r = bus.btn_right & ~r_hist_r;
  assign w_ev_d = bus.btn_drop  & ~r_hist_d;

  // Button history keeps updating in every state so a held button never
  // re-fires once the controller returns to SELECT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist_l <= 1'b0;
      r_hist_r <= 1'b0;
      r_hist_d <= 1'b0;
    end else begin
      r_hist_l <= bus.btn_left;
      r_hist_r <= bus.btn_right;
      r_hist_d <= bus.btn_drop;
    end
  end

  // Pick the cursor column's count and detect a completely filled board.
  // A field above NUM_ROWS counts as full.
  always_comb begin
    w_cur_count = 3'd0;
    w_all_full  = 1'b1;
    for (int c = 1; c <= NUM_COLS; c++) begin
      if (bus.counts[3*(c-1) +: 3] < LP_FULL) w_all_full = 1'b0;
      if (r_cursor == 4'(c))                   w_cur_count = bus.counts[3*(c-1) +: 3];
    end
    w_col_full = (w_cur_count >= LP_FULL);
  end

  // Next-state and next-output decisions for the move FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_cursor_nxt   = r_cursor;
    w_drop_col_nxt = 4'd0;
    w_drop_row_nxt = r_drop_row;
    w_player_nxt   = r_player;
    w_reject_nxt   = 1'b0;
    w_draw_nxt     = r_draw;
    w_over_nxt     = r_over;
    case (r_state)
      SELECT: begin
        // A drop takes priority over any simultaneous cursor move.
        if (w_ev_d) begin
          if (w_col_full) begin
            w_reject_nxt = 1'b1;
          end else begin
            w_state_nxt    = DROP;
            w_drop_col_nxt = r_cursor;
            w_drop_row_nxt = w_cur_count;
          end
        end else if (w_ev_l && !w_ev_r) begin
          w_cursor_nxt = (r_cursor == 4'd1) ? LP_LAST : r_cursor - 4'd1;
        end else if (w_ev_r && !w_ev_l) begin
          w_cursor_nxt = (r_cursor == LP_LAST) ? 4'd1 : r_cursor + 4'd1;
        end
      end
      DROP: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // Counters and the win checker have settled by now.
        if (bus.game_won) begin
          w_state_nxt = OVER;
          w_over_nxt  = 1'b1;
        end else if (w_all_full) begin
          w_state_nxt = OVER;
          w_draw_nxt  = 1'b1;
          w_over_nxt  = 1'b1;
        end else begin
          w_state_nxt  = SELECT;
          w_player_nxt = ~r_player;
        end
      end
      OVER: begin
        w_state_nxt = OVER;
      end
      default: begin
        w_state_nxt = SELECT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= SELECT;
    else       r_state <= w_state_nxt;
  end

  // Registered outputs; reset wins in every state, including mid-drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cursor   <= LP_START;
      r_drop_col <= 4'd0;
      r_drop_row <= 3'd0;
      r_player   <= 1'b0;
      r_reject   <= 1'b0;
      r_draw     <= 1'b0;
      r_over     <= 1'b0;
    end else begin
      r_cursor   <= w_cursor_nxt;
      r_drop_col <= w_drop_col_nxt;
      r_drop_row <= w_drop_row_nxt;
      r_player   <= w_player_nxt;
      r_reject   <= w_reject_nxt;
      r_draw     <= w_draw_nxt;
      r_over     <= w_over_nxt;
    end
  end

  assign bus.cursor      = r_cursor;
  assign bus.drop_column = r_drop_col;
  assign bus.drop_row    = r_drop_row;
  assign bus.player      = r_player;
  assign bus.reject      = r_reject;
  assign bus.draw        = r_draw;
  assign bus.game_over   = r_over;

endmodule

// File: tb/tb_move_controller.sv
// Directed-vector bench for move_controller with hand-computed expectations.
module tb_move_controller;

  localparam int NUM_COLS = 7;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   n_extra;

  move_if #(.NUM_COLS(NUM_COLS)) bus ();

  move_controller #(
    .NUM_COLS (NUM_COLS),
    .NUM_ROWS (6),
    .START_COL(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle button pulse followed by one idle cycle.
  task automatic press(input logic l, input logic r, input logic d);
    bus.btn_left  = l;
    bus.btn_right = r;
    bus.btn_drop  = d;
    tick();
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_drop  = 1'b0;
    tick();
  endtask

  task automatic set_count(input int c, input logic [2:0] v);
    bus.counts[3*(c-1) +: 3] = v;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_drop  = 1'b0;
    bus.counts    = '0;
    bus.game_won  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_cursor", int'(bus.cursor), 4);
    chk("rst_dropcol", int'(bus.drop_column), 0);
    chk("rst_droprow", int'(bus.drop_row), 0);
    chk("rst_player", int'(bus.player), 0);
    chk("rst_reject", int'(bus.reject), 0);
    chk("rst_draw", int'(bus.draw), 0);
    chk("rst_over", int'(bus.game_over), 0);

    // Cursor walk with wrap in both directions
    press(0, 1, 0); chk("right_5", int'(bus.cursor), 5);
    press(0, 1, 0); chk("right_6", int'(bus.cursor), 6);
    press(0, 1, 0); chk("right_7", int'(bus.cursor), 7);
    press(0, 1, 0); chk("right_wrap", int'(bus.cursor), 1);
    press(1, 0, 0); chk("left_wrap", int'(bus.cursor), 7);
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    chk("left_to_4", int'(bus.cursor), 4);

    // Held drop into column 4 with 2 tokens: one drop only
    set_count(4, 3'd2);
    bus.btn_drop = 1'b1;
    tick();
    chk("drop_col", int'(bus.drop_column), 4);
    chk("drop_row", int'(bus.drop_row), 2);
    chk("drop_player", int'(bus.player), 0);
    set_count(4, 3'd3);
    tick();
    chk("drop_col_clear", int'(bus.drop_column), 0);
    chk("wait_player", int'(bus.player), 0);
    tick();
    chk("player_toggle", int'(bus.player), 1);
    n_extra = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.drop_column != 4'd0) n_extra++;
    end
    chk("held_no_redrop", n_extra, 0);
    bus.btn_drop = 1'b0;
    tick();

    // Drop into a full column is rejected
    press(1, 0, 0);
    chk("cursor_3", int'(bus.cursor), 3);
    set_count(3, 3'd6);
    bus.btn_drop = 1'b1;
    tick();
    chk("reject_pulse", int'(bus.reject), 1);
    chk("reject_nodrop", int'(bus.drop_column), 0);
    bus.btn_drop = 1'b0;
    tick();
    chk("reject_end", int'(bus.reject), 0);
    chk("reject_player", int'(bus.player), 1);
    chk("reject_cursor", int'(bus.cursor), 3);
    press(0, 1, 0);
    chk("still_select", int'(bus.cursor), 4);

    // Simultaneous events
    press(1, 1, 0);
    chk("lr_ignored", int'(bus.cursor), 4);
    bus.btn_drop  = 1'b1;
    bus.btn_right = 1'b1;
    tick();
    chk("dr_dropcol", int'(bus.drop_column), 4);
    chk("dr_droprow", int'(bus.drop_row), 3);
    chk("dr_cursor", int'(bus.cursor), 4);
    bus.btn_drop  = 1'b0;
    bus.btn_right = 1'b0;
    set_count(4, 3'd4);
    tick();
    tick();
    chk("dr_cursor_after", int'(bus.cursor), 4);
    chk("dr_player", int'(bus.player), 0);

    // Win: game freezes, player identifies winner
    bus.btn_drop = 1'b1;
    tick();
    chk("win_dropcol", int'(bus.drop_column), 4);
    bus.btn_drop = 1'b0;
    bus.game_won = 1'b1;
    set_count(4, 3'd5);
    tick();
    tick();
    chk("win_over", int'(bus.game_over), 1);
    chk("win_draw", int'(bus.draw), 0);
    chk("win_player", int'(bus.player), 0);
    bus.game_won = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.btn_drop = 1'b1;
      tick();
      chk("over_nodrop", int'(bus.drop_column), 0);
      bus.btn_drop = 1'b0;
      tick();
    end
    press(0, 1, 0);
    chk("over_cursor", int'(bus.cursor), 4);
    chk("over_hold", int'(bus.game_over), 1);

    // Draw: last token fills the board
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= NUM_COLS; c++) set_count(c, 3'd6);
    set_count(7, 3'd5);
    press(0, 1, 0); press(0, 1, 0); press(0, 1, 0);
    chk("draw_cursor", int'(bus.cursor), 7);
    bus.btn_drop = 1'b1;
    tick();
    chk("draw_dropcol", int'(bus.drop_column), 7);
    chk("draw_droprow", int'(bus.drop_row), 5);
    bus.btn_drop = 1'b0;
    set_count(7, 3'd6);
    tick();
    tick();
    chk("draw_flag", int'(bus.draw), 1);
    chk("draw_over", int'(bus.game_over), 1);
    chk("draw_player", int'(bus.player), 0);

    // Reset in the middle of a drop
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.counts = '0;
    chk("rst2_draw", int'(bus.draw), 0);
    chk("rst2_over", int'(bus.game_over), 0);
    bus.btn_drop = 1'b1;
    tick();
    chk("mid_dropcol", int'(bus.drop_column), 4);
    reset = 1'b1;
    tick();
    chk("mid_rst_dropcol", int'(bus.drop_column), 0);
    chk("mid_rst_cursor", int'(bus.cursor), 4);
    chk("mid_rst_player", int'(bus.player), 0);
    reset = 1'b0;
    bus.btn_drop = 1'b0;
    tick();
    chk("mid_rst_idle", int'(bus.drop_column), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past time limit");
    $fatal(1);
  end

endmodule
